clk_div_multi: RTL

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_pkg.sv | 10 +
 rtl/clk_div_chan.sv | 61 ++++++
 rtl/clk_div_multi.sv | 38 +++
 3 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults and the channel-index width helper for clk_div_multi.
package clk_div_pkg;
  localparam int NUM_CH_DEF = 4;
  localparam int WIDTH_DEF = 24;
  localparam logic [WIDTH_DEF-1:0] DEF_DIV_DEF = 24'd12_000_000;
  // A single channel still needs a one-bit index port.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel; shadowed ratio is applied only at a period boundary.
// Define CLK_DIV_ODD50_EN to add a falling-edge phase copy giving 50% duty for odd ratios.
module clk_div_chan import clk_div_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEF_DIV_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             pend_o,
  output logic             clkout_o,
  output logic             tick_o
);
  logic [WIDTH-1:0] act_q, act_d, shd_q, shd_d, cnt_q, cnt_d;
  logic pend_q, pend_d, phase_q, phase_d, tick_q, tick_d, en_q;
  logic run, wrap, apply, phase_out;
  always_comb begin
    run = en_i && act_q != '0;
    wrap = cnt_q == act_q - WIDTH'(1);
    apply = pend_q && (!run || wrap);
    act_d = apply ? shd_q : act_q;
    shd_d = wr_i ? div_i : shd_q;
    pend_d = wr_i || (pend_q && !apply);
    cnt_d = (!run || wrap) ? '0 : cnt_q + WIDTH'(1);
    phase_d = run && act_q > WIDTH'(1) && cnt_q >= (act_q >> 1);
    tick_d = run && wrap;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act_q <= DEF_DIV;
      shd_q <= DEF_DIV;
      pend_q <= 1'b0;
      cnt_q <= '0;
      phase_q <= 1'b0;
      tick_q <= 1'b0;
      en_q <= 1'b0;
    end else begin
      act_q <= act_d;
      shd_q <= shd_d;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      tick_q <= tick_d;
      en_q <= en_i;
    end
`ifdef CLK_DIV_ODD50_EN
  logic phase_n_q;
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) phase_n_q <= 1'b0;
    else phase_n_q <= phase_q;
  // Odd ratios trim half a clk off the long high phase.
  assign phase_out = (act_q[0] && act_q > WIDTH'(1)) ? phase_q && phase_n_q : phase_q;
`else
  assign phase_out = phase_q;
`endif
  assign clkout_o = (act_q == WIDTH'(1)) ? clk && en_q : phase_out;
  assign pend_o = pend_q;
  assign tick_o = tick_q;
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent clock dividers with a shared ratio-write port.
// Optional CLK_DIV_ODD50_EN gives 50% duty on odd ratios (see clk_div_chan).
module clk_div_multi import clk_div_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEF_DIV_DEF),
  localparam int CW = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] clkout,
  output logic [NUM_CH-1:0] tick
);
  logic [NUM_CH-1:0] pend, wr;
  // Out-of-range indices match no channel, so they stay ready and write nothing.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) if (cfg_ch == CW'(i)) cfg_ready = !pend[i];
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr[g] = cfg_valid && cfg_ready && cfg_ch == CW'(g);
    clk_div_chan #(.WIDTH(WIDTH), .DEF_DIV(DEF_DIV)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (ch_en[g]),
      .wr_i     (wr[g]),
      .div_i    (cfg_div),
      .pend_o   (pend[g]),
      .clkout_o (clkout[g]),
      .tick_o   (tick[g])
    );
  end
endmodule
